// File: rtl/freq_div_meas.sv
// Counts rising edges of an asynchronous divided clock over a programmable
// window of CLK cycles and holds the result behind a valid/ack handshake.
module freq_div_meas #(
  parameter int GATE_W      = 16,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              CLK,
  input  logic              RESETB,
  input  logic              START,
  input  logic [GATE_W-1:0] GATE_CYCLES,
  input  logic              FREQ_DIV_IN,
  output logic              BUSY,
  output logic [CNT_W-1:0]  CNT_OUT,
  output logic              CNT_VALID,
  output logic              CNT_OVF,
  input  logic              CNT_ACK
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GATE = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic [GATE_W-1:0]      r_gate_cnt;
  logic [CNT_W-1:0]       r_edge_cnt;
  logic                   r_ovf_run;
  logic [CNT_W-1:0]       r_cnt_out;
  logic                   r_cnt_ovf;
  logic                   r_cnt_valid;

  logic                   w_sync_last;
  logic                   w_rise;
  logic                   w_sat;
  logic [CNT_W-1:0]       w_edge_nxt;
  logic                   w_ovf_nxt;
  logic                   w_load;
  logic                   w_finish;

  assign w_sync_last = r_sync[SYNC_STAGES-1];
  assign w_rise      = w_sync_last & ~r_prev;
  assign w_sat       = &r_edge_cnt;
  // Overflow flags an edge that arrived while the counter was already pinned.
  assign w_edge_nxt  = (w_rise && !w_sat) ? r_edge_cnt + CNT_W'(1) : r_edge_cnt;
  assign w_ovf_nxt   = r_ovf_run | (w_rise & w_sat);

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      if (SYNC_STAGES > 1) r_sync <= {r_sync[SYNC_STAGES-2:0], FREQ_DIV_IN};
      else                 r_sync <= FREQ_DIV_IN;
      r_prev <= w_sync_last;
    end
  end

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (START && (GATE_CYCLES != '0)) begin
          w_state_nxt = ST_GATE;
          w_load      = 1'b1;
        end
      end
      ST_GATE: begin
        if (r_gate_cnt == GATE_W'(1)) begin
          w_state_nxt = ST_DONE;
          w_finish    = 1'b1;
        end
      end
      ST_DONE: begin
        if (CNT_ACK) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Result registers stay untouched by a new START so they survive until the next completion.
  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      r_gate_cnt  <= '0;
      r_edge_cnt  <= '0;
      r_ovf_run   <= 1'b0;
      r_cnt_out   <= '0;
      r_cnt_ovf   <= 1'b0;
      r_cnt_valid <= 1'b0;
    end else begin
      if (w_load) begin
        r_gate_cnt <= GATE_CYCLES;
        r_edge_cnt <= '0;
        r_ovf_run  <= 1'b0;
      end else if (r_state == ST_GATE) begin
        r_gate_cnt <= r_gate_cnt - GATE_W'(1);
        r_edge_cnt <= w_edge_nxt;
        r_ovf_run  <= w_ovf_nxt;
      end
      if (w_finish) begin
        r_cnt_out   <= w_edge_nxt;
        r_cnt_ovf   <= w_ovf_nxt;
        r_cnt_valid <= 1'b1;
      end else if ((r_state == ST_DONE) && CNT_ACK) begin
        r_cnt_valid <= 1'b0;
      end
    end
  end

  assign BUSY      = (r_state == ST_GATE);
  assign CNT_OUT   = r_cnt_out;
  assign CNT_VALID = r_cnt_valid;
  assign CNT_OVF   = r_cnt_ovf;

endmodule
